// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: PC sequencing, execute-stage redirects, wrong-path flush and misalignment fault.
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ex_valid,
  input  logic        i_jump_cntr,
  input  logic [31:0] i_target,
  input  logic        i_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  output logic        o_ex_ack,
  output logic        o_flush,
  output logic        o_fault,
  output logic [15:0] o_redirect_cnt
);
  typedef enum logic [1:0] {BOOT, RUN, FLUSH, FAULT} state_t;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [2:0]  r_flush_cnt, w_fcnt_nxt;
  logic [15:0] r_redirect_cnt, w_rcnt_nxt;
  logic        w_req, w_ack, w_aligned;
  assign w_req     = (r_state == RUN || r_state == FLUSH) && !i_stall;
  assign w_ack     = r_state == RUN && i_ex_valid && i_jump_cntr && !i_stall;
  assign w_aligned = i_target[1:0] == 2'b00;
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = (w_req && i_imem_ready) ? r_pc + 32'd4 : r_pc;
    w_fcnt_nxt  = r_flush_cnt;
    w_rcnt_nxt  = r_redirect_cnt;
    case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN: if (w_ack) begin
        // redirect wins over the same-cycle PC+4; a bad target freezes the PC
        w_state_nxt = w_aligned ? FLUSH : FAULT;
        w_pc_nxt    = w_aligned ? i_target : r_pc;
        w_fcnt_nxt  = w_aligned ? 3'(FLUSH_CYCLES) : r_flush_cnt;
        w_rcnt_nxt  = (w_aligned && r_redirect_cnt != 16'hFFFF) ? r_redirect_cnt + 16'd1 : r_redirect_cnt;
      end
      FLUSH: if (!i_stall) begin
        w_fcnt_nxt  = r_flush_cnt - 3'd1;
        w_state_nxt = (r_flush_cnt == 3'd1) ? RUN : FLUSH;
      end
      default: w_pc_nxt = r_pc;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= BOOT;
      r_pc           <= RESET_ADDR;
      r_flush_cnt    <= 3'd0;
      r_redirect_cnt <= 16'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_flush_cnt    <= w_fcnt_nxt;
      r_redirect_cnt <= w_rcnt_nxt;
    end
  end
  assign o_imem_req     = w_req;
  assign o_imem_addr    = r_pc;
  assign o_ex_ack       = w_ack;
  assign o_flush        = r_state == FLUSH || r_state == FAULT;
  assign o_fault        = r_state == FAULT;
  assign o_redirect_cnt = r_redirect_cnt;
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: directed checks of fetch sequencing, redirect, flush, stall, wrap, saturation and fault.
module tb_fetch_redirect_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, jump = 1'b0, stall = 1'b0, ready = 1'b1;
  logic [31:0] target = 32'd0;
  logic        req, ack, flush, fault;
  logic [31:0] addr;
  logic [15:0] rcnt;
  int          n_cmp = 0, n_err = 0;

  fetch_redirect_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_ex_valid(ex_valid), .i_jump_cntr(jump),
    .i_target(target), .i_stall(stall), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_ready(ready), .o_ex_ack(ack), .o_flush(flush), .o_fault(fault),
    .o_redirect_cnt(rcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tk(input logic v, input logic j, input logic [31:0] t);
    @(negedge clk);
    ex_valid = v;
    jump = j;
    target = t;
    #1;
  endtask

  initial begin
    tk(1, 1, 32'h40);
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 0);
    chk("rst_ack", ack, 0);
    chk("rst_flush", flush, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cnt", rcnt, 0);
    tk(0, 0, 0);
    rst = 1'b0;
    #1;
    chk("boot_req", req, 0);
    tk(0, 0, 0);
    chk("boot_req_rise", req, 1);
    chk("seq_a0", addr, 32'h0);
    chk("seq_flush0", flush, 0);
    tk(1, 0, 32'h500);
    chk("seq_a4", addr, 32'h4);
    chk("not_taken_ack", ack, 0);
    // N: taken branch to 0x100 while a fetch is also accepted
    tk(1, 1, 32'h100);
    chk("seq_a8", addr, 32'h8);
    chk("br1_ack", ack, 1);
    tk(0, 0, 0);
    chk("br1_addr", addr, 32'h100);
    chk("br1_flush1", flush, 1);
    chk("br1_ack_n1", ack, 0);
    tk(1, 1, 32'h200);
    chk("br2_ignored", ack, 0);
    chk("br1_flush2", flush, 1);
    chk("br1_addr2", addr, 32'h104);
    tk(1, 1, 32'h200);
    chk("br1_flush_end", flush, 0);
    chk("br2_ack", ack, 1);
    chk("br1_addr3", addr, 32'h108);
    tk(0, 0, 0);
    chk("br2_addr", addr, 32'h200);
    chk("br2_cnt", rcnt, 2);
    tk(0, 0, 0);
    tk(1, 1, 32'h100);
    chk("br3_ack", ack, 1);
    // stall in the first flush cycle stretches the flush to three cycles
    @(negedge clk);
    ex_valid = 1'b0; jump = 1'b0; stall = 1'b1;
    #1;
    chk("st_addr1", addr, 32'h100);
    chk("st_flush1", flush, 1);
    chk("st_req", req, 0);
    @(negedge clk);
    stall = 1'b0;
    #1;
    chk("st_addr2", addr, 32'h100);
    chk("st_flush2", flush, 1);
    tk(0, 0, 0);
    chk("st_flush3", flush, 1);
    chk("st_addr3", addr, 32'h104);
    tk(1, 1, 32'hFFFF_FFFC);
    chk("st_flush4", flush, 0);
    chk("wrap_ack", ack, 1);
    tk(0, 0, 0);
    chk("wrap_a0", addr, 32'hFFFF_FFFC);
    chk("wrap_cnt", rcnt, 4);
    tk(0, 0, 0);
    chk("wrap_a1", addr, 32'h0);
    @(negedge clk);
    ready = 1'b0;
    #1;
    chk("hold_a0", addr, 32'h4);
    chk("run_after_wrap", flush, 0);
    @(negedge clk);
    ready = 1'b1;
    #1;
    chk("hold_a1", addr, 32'h4);
    tk(0, 0, 0);
    chk("hold_a2", addr, 32'h8);
    force dut.r_redirect_cnt = 16'hFFFE;
    #1;
    release dut.r_redirect_cnt;
    tk(1, 1, 32'h300);
    chk("sat_ack1", ack, 1);
    tk(0, 0, 0);
    chk("sat_cnt1", rcnt, 16'hFFFF);
    tk(0, 0, 0);
    tk(1, 1, 32'h400);
    chk("sat_ack2", ack, 1);
    tk(0, 0, 0);
    tk(0, 0, 0);
    tk(1, 1, 32'h500);
    chk("sat_ack3", ack, 1);
    tk(0, 0, 0);
    chk("sat_cnt3", rcnt, 16'hFFFF);
    chk("sat_flush", flush, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_flush", flush, 0);
    chk("mid_rst_cnt", rcnt, 0);
    chk("mid_rst_req", req, 0);
    chk("mid_rst_addr", addr, 32'h0);
    tk(0, 0, 0);
    rst = 1'b0;
    tk(0, 0, 0);
    chk("rerun_req", req, 1);
    tk(1, 1, 32'h102);
    chk("mis_ack", ack, 1);
    chk("mis_addr_pre", addr, 32'h4);
    tk(1, 1, 32'h200);
    chk("mis_fault", fault, 1);
    chk("mis_req", req, 0);
    chk("mis_flush", flush, 1);
    chk("mis_cnt", rcnt, 0);
    chk("mis_ack_ign", ack, 0);
    chk("mis_addr", addr, 32'h4);
    tk(0, 0, 0);
    chk("mis_sticky", fault, 1);
    chk("mis_addr_hold", addr, 32'h4);
    rst = 1'b1;
    #1;
    chk("fault_rst", fault, 0);
    chk("fault_rst_addr", addr, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Sequences the program counter and instruction-memory fetch requests for the core. It consumes the execute-stage control-flow decision from the branch controller, redirects fetch to the resolved target, and squashes the wrong-path instructions behind it for a fixed number of pipeline advances. Misaligned targets trap the block in a fault state. It sits between the execute stage, the IF/ID/EX pipeline registers and the instruction memory port.

## Interface
- RESET_ADDR, 32'h0000_0000: first fetch address after reset; must be 4-byte aligned.
- FLUSH_CYCLES, 2: number of pipeline advances squashed after a redirect; legal range 1..7.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_ex_valid  in  1  execute stage holds a valid instruction this cycle.
- i_jump_cntr  in  1  taken decision from branch control: jump, or branch condition met.
- i_target  in  32  resolved jump/branch target.
- i_stall  in  1  pipeline stall; freezes PC advance and the flush count.
- o_imem_req  out  1  fetch request valid.
- o_imem_addr  out  32  fetch address; equals the PC register.
- i_imem_ready  in  1  instruction memory accepts the request this cycle.
- o_ex_ack  out  1  redirect accepted this cycle (combinational).
- o_flush  out  1  squash younger pipeline slots.
- o_fault  out  1  misaligned redirect target; sticky until reset.
- o_redirect_cnt  out  16  number of accepted redirects; saturates.

## Operation
- States:
  - BOOT: reset state.
  - RUN: normal fetch.
  - FLUSH: squashing the wrong path.
  - FAULT: misaligned target trapped.
- Reset values:
  - o_imem_req=0, o_imem_addr=RESET_ADDR.
  - o_ex_ack=0, o_flush=0, o_fault=0.
  - o_redirect_cnt=0, state=BOOT.
- BOOT always goes to RUN on the next edge.
- o_imem_req = (state is RUN or FLUSH) and !i_stall.
- Fetch advance: when o_imem_req and i_imem_ready, PC <= PC+4, mod 2^32. 32'hFFFF_FFFC wraps to 0.
- Redirect acceptance: state==RUN and i_ex_valid and i_jump_cntr and !i_stall. o_ex_ack=1 in that cycle.
  - Aligned target (i_target[1:0]==0):
    - PC <= i_target.
    - Flush counter <= FLUSH_CYCLES.
    - State goes to FLUSH.
    - o_redirect_cnt increments, saturating at 16'hFFFF.
  - Misaligned target:
    - PC unchanged.
    - State goes to FAULT.
    - Counter does not increment.
  - A redirect has priority over a same-cycle fetch advance. The PC+4 update is discarded, and the data of the already-accepted fetch is squashed by the flush.
- FLUSH:
  - o_flush=1 and fetch continues normally from the target.
  - i_ex_valid and i_jump_cntr are ignored because those slots are wrong-path; o_ex_ack=0.
  - Counter decrements on each cycle with !i_stall.
  - When counter==1 and !i_stall, state goes to RUN.
- FAULT:
  - o_fault=1, o_imem_req=0, o_flush=1.
  - All inputs are ignored; only i_rst exits.
- Asserting i_rst in any state immediately forces all reset values, including mid-flush and mid-fetch.
- i_ex_valid with i_jump_cntr=0 (not taken) does not change state.

## Timing
- Redirect accepted in cycle N:
  - o_imem_addr=i_target from N+1.
  - o_flush high N+1..N+FLUSH_CYCLES when there is no stall.
  - RUN again at N+FLUSH_CYCLES+1, which is the earliest next o_ex_ack.
- Each stalled cycle inside FLUSH extends o_flush by one cycle.
- Reset release at edge R: o_imem_req rises in the cycle after R with address RESET_ADDR.
- Fetch throughput: one request per cycle while i_imem_ready=1. The address holds while i_imem_ready=0.
- Misaligned target in cycle N: o_fault=1 and o_imem_req=0 from N+1.
- o_ex_ack is combinational from registered state and inputs. All other outputs depend only on registered state and i_stall.

## Test plan
- Reset release with RESET_ADDR=0 and i_imem_ready=1 constant -> addresses 0x0, 0x4, 0x8 on successive cycles. o_flush=0 and o_ex_ack=0 throughout.
- Taken branch with target 0x100 in cycle N, FLUSH_CYCLES=2 -> o_ex_ack=1 at N, o_imem_addr=0x100 at N+1, o_flush=1 at N+1..N+2. A second taken branch at N+2 is ignored and one at N+3 is accepted. o_redirect_cnt=2.
- i_stall=1 at N+1 after a redirect -> o_flush lasts three cycles (N+1..N+3) and o_imem_addr stays at 0x100 through the stall.
- Redirect to 0x102 -> o_fault=1 and o_imem_req=0 from N+1, o_redirect_cnt unchanged. Further taken branches are ignored until i_rst, after which o_imem_addr=RESET_ADDR.
- PC 0xFFFF_FFFC accepted with i_imem_ready=1 -> next address 0x0000_0000. Redirect and fetch accept in the same cycle -> next address is the target, not PC+4.
- Preload the counter to 16'hFFFE, then perform three redirects -> o_redirect_cnt reads 16'hFFFF. Asserting i_rst mid-FLUSH clears o_flush and the counter immediately.
